tipi_mmio_fifo: RTL and testbench

//  Successor to the single-byte TC/TD/RC/RD latches: FIFO-backed TI<->Pi mailbox behind the same 4-register MMIO window.
//  TI writes to TD push into a TX FIFO that the Pi side drains; Pi-side bytes fill an RX FIFO that the TI pops via RD.

---
 rtl/tipi_mmio_fifo.sv | 170 +++++++++++++++++
 tb/tb_tipi_mmio_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_mmio_fifo.sv
// rtl/tipi_mmio_fifo.sv - FIFO-backed TI<->Pi mailbox behind a 4-register MMIO window
// TI side sees STAT/CTRL, RX data, RX count and TX data registers; Pi side sees valid/ready byte streams.
module tipi_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic [7:0]          wdata,
  input  logic                pop,
  output logic [7:0]          rdata,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop on the same edge frees the slot, so full+pop+push is accepted.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{DEPTH_LOG2{1'b0}}, push_ok} - {{DEPTH_LOG2{1'b0}}, pop_ok};
    end
  end
endmodule

module tipi_mmio_fifo #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] RC_ADDR    = 16'h5ff9,
  parameter logic [15:0] RD_ADDR    = 16'h5ffb,
  parameter logic [15:0] TC_ADDR    = 16'h5ffd,
  parameter logic [15:0] TD_ADDR    = 16'h5fff
) (
  input  logic        ti_ph3,
  input  logic        ti_reset_n,
  input  logic        dev_en,
  input  logic [0:15] ti_a,
  input  logic        ti_memen,
  input  logic        ti_we,
  input  logic        ti_dbin,
  input  logic [0:7]  ti_d_in,
  output logic [0:7]  ti_d_out,
  output logic        ti_d_oe,
  output logic        ti_extint_n,
  output logic [7:0]  pi_tx_data,
  output logic        pi_tx_valid,
  input  logic        pi_tx_ready,
  input  logic [7:0]  pi_rx_data,
  input  logic        pi_rx_valid,
  output logic        pi_rx_ready
);
  logic [3:0]          hit;
  logic                bus_ok;
  logic [3:0]          wr_acc, rd_acc, wr_prev, rd_prev, wr_fire;
  logic                ctrl_wr, td_wr, rx_pop_req;
  logic                flush_tx, flush_rx;
  logic                tx_ovf, rx_ovf, rx_unf, irq_en;
  logic [7:0]          td_last;
  logic [7:0]          rx_head;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic                tx_empty, tx_full, rx_empty, rx_full;
  logic [0:7]          stat;

  assign hit     = {ti_a == TD_ADDR, ti_a == TC_ADDR, ti_a == RD_ADDR, ti_a == RC_ADDR};
  assign bus_ok  = dev_en & ~ti_memen;
  assign wr_acc  = {4{bus_ok & ~ti_we}} & hit;
  assign rd_acc  = {4{bus_ok & ti_dbin}} & hit;
  assign wr_fire = wr_acc & ~wr_prev;
  assign ctrl_wr = wr_fire[0];
  assign td_wr   = wr_fire[3];
  // RD pops on the trailing edge of the read so the byte stays put while the CPU samples it.
  assign rx_pop_req = rd_prev[1] & ~rd_acc[1];

  assign flush_tx = ctrl_wr & ti_d_in[7];
  assign flush_rx = ctrl_wr & ti_d_in[6];

  assign pi_tx_valid = ~tx_empty;
  assign pi_rx_ready = ~rx_full | (rx_pop_req & ~rx_empty);
  assign ti_d_oe     = bus_ok & ti_dbin & (ti_a >= RC_ADDR) & (ti_a <= TD_ADDR);

  tipi_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (ti_ph3),
    .rst_n (ti_reset_n),
    .flush (flush_tx),
    .push  (td_wr),
    .wdata (ti_d_in),
    .pop   (pi_tx_ready),
    .rdata (pi_tx_data),
    .count (tx_count),
    .empty (tx_empty),
    .full  (tx_full)
  );

  tipi_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (ti_ph3),
    .rst_n (ti_reset_n),
    .flush (flush_rx),
    .push  (pi_rx_valid & pi_rx_ready),
    .wdata (pi_rx_data),
    .pop   (rx_pop_req),
    .rdata (rx_head),
    .count (rx_count),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign stat = {irq_en, 1'b0, rx_unf, tx_ovf, rx_ovf, tx_empty, tx_full, ~rx_empty};

  always_comb begin
    ti_d_out = 8'h00;
    if (rd_acc[0])      ti_d_out = stat;
    else if (rd_acc[1]) ti_d_out = rx_empty ? 8'h00 : rx_head;
    else if (rd_acc[2]) ti_d_out = 8'(rx_count);
    else if (rd_acc[3]) ti_d_out = td_last;
  end

  // wr_prev resets high so a write still held when reset releases is not taken as new.
  always_ff @(posedge ti_ph3 or negedge ti_reset_n) begin
    if (!ti_reset_n) begin
      wr_prev     <= '1;
      rd_prev     <= '0;
      tx_ovf      <= 1'b0;
      rx_ovf      <= 1'b0;
      rx_unf      <= 1'b0;
      irq_en      <= 1'b0;
      td_last     <= 8'h00;
      ti_extint_n <= 1'b1;
    end else begin
      wr_prev     <= wr_acc;
      rd_prev     <= rd_acc;
      ti_extint_n <= ~(irq_en & ~rx_empty);
      if (td_wr) td_last <= ti_d_in;
      if (ctrl_wr) irq_en <= ti_d_in[0];
      if (ctrl_wr && ti_d_in[5]) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end
      if (td_wr && tx_full && !pi_tx_ready) tx_ovf <= 1'b1;
      if (rx_pop_req && rx_empty) rx_unf <= 1'b1;
      if (flush_rx && !rx_empty && pi_rx_valid) rx_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tipi_mmio_fifo.sv
// tb/tb_tipi_mmio_fifo.sv - randomized scenario bench for tipi_mmio_fifo
// Queue-based mailbox model; each test task compares DUT behaviour against it inline.
module tb_tipi_mmio_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] RC = 16'h5ff9;
  localparam logic [15:0] RD = 16'h5ffb;
  localparam logic [15:0] TC = 16'h5ffd;
  localparam logic [15:0] TD = 16'h5fff;

  logic        ti_ph3 = 1'b0;
  logic        ti_reset_n = 1'b0;
  logic        dev_en = 1'b1;
  logic [0:15] ti_a = 16'h0000;
  logic        ti_memen = 1'b1;
  logic        ti_we = 1'b1;
  logic        ti_dbin = 1'b0;
  logic [0:7]  ti_d_in = 8'h00;
  logic [0:7]  ti_d_out;
  logic        ti_d_oe;
  logic        ti_extint_n;
  logic [7:0]  pi_tx_data;
  logic        pi_tx_valid;
  logic        pi_tx_ready = 1'b0;
  logic [7:0]  pi_rx_data = 8'h00;
  logic        pi_rx_valid = 1'b0;
  logic        pi_rx_ready;

  int passed = 0;
  int total = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_tx_ovf, m_rx_ovf, m_rx_unf, m_irq_en;
  logic [7:0] m_td_last;

  tipi_mmio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .ti_ph3(ti_ph3), .ti_reset_n(ti_reset_n), .dev_en(dev_en), .ti_a(ti_a),
    .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_d_in(ti_d_in),
    .ti_d_out(ti_d_out), .ti_d_oe(ti_d_oe), .ti_extint_n(ti_extint_n),
    .pi_tx_data(pi_tx_data), .pi_tx_valid(pi_tx_valid), .pi_tx_ready(pi_tx_ready),
    .pi_rx_data(pi_rx_data), .pi_rx_valid(pi_rx_valid), .pi_rx_ready(pi_rx_ready)
  );

  always #5 ti_ph3 = ~ti_ph3;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_stat();
    return {m_irq_en, 1'b0, m_rx_unf, m_tx_ovf, m_rx_ovf,
            tx_q.size() == 0, tx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  task automatic model_reset();
    tx_q.delete(); rx_q.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_unf = 0; m_irq_en = 0; m_td_last = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge ti_ph3); ti_a = addr; ti_d_in = data; ti_memen = 0; ti_we = 0;
    @(negedge ti_ph3); ti_memen = 1; ti_we = 1;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] data, output logic oe);
    @(negedge ti_ph3); ti_a = addr; ti_memen = 0; ti_dbin = 1;
    @(negedge ti_ph3); data = ti_d_out; oe = ti_d_oe; ti_memen = 1; ti_dbin = 0;
  endtask

  task automatic td_write(input logic [7:0] b);
    bus_write(TD, b);
    if (tx_q.size() < DEPTH) tx_q.push_back(b); else m_tx_ovf = 1;
    m_td_last = b;
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    bus_write(RC, v);
    if (v[0]) tx_q.delete();
    if (v[1]) rx_q.delete();
    if (v[2]) begin m_tx_ovf = 0; m_rx_ovf = 0; m_rx_unf = 0; end
    m_irq_en = v[7];
  endtask

  task automatic rd_read(output logic [7:0] got, output logic [7:0] exp);
    logic oe;
    bus_read(RD, got, oe);
    if (rx_q.size() > 0) exp = rx_q.pop_front();
    else begin exp = 8'h00; m_rx_unf = 1; end
  endtask

  task automatic pi_push(input logic [7:0] b, output logic rdy, output logic exp_rdy);
    @(negedge ti_ph3); pi_rx_data = b; pi_rx_valid = 1;
    #1 rdy = pi_rx_ready;
    exp_rdy = (rx_q.size() < DEPTH);
    @(negedge ti_ph3); pi_rx_valid = 0;
    if (exp_rdy) rx_q.push_back(b);
  endtask

  task automatic pi_pop(output logic v, output logic [7:0] d);
    @(negedge ti_ph3); v = pi_tx_valid; d = pi_tx_data; pi_tx_ready = 1;
    @(posedge ti_ph3); #1 pi_tx_ready = 0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic oe;
    ti_reset_n = 0;
    repeat (3) @(negedge ti_ph3);
    total++; if (ti_d_out !== 8'h00) $display("FAIL rst_dout got %h exp 00", ti_d_out); else passed++;
    total++; if ({ti_d_oe, ti_extint_n, pi_tx_valid, pi_rx_ready} !== 4'b0101)
      $display("FAIL rst_ctl got %b exp 0101", {ti_d_oe, ti_extint_n, pi_tx_valid, pi_rx_ready}); else passed++;
    ti_reset_n = 1;
    model_reset();
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat() || oe !== 1'b1) $display("FAIL rst_stat got %h/%b exp %h/1", d, oe, exp_stat()); else passed++;
    bus_read(TC, d, oe);
    total++; if (d !== 8'h00) $display("FAIL rst_tc got %h exp 00", d); else passed++;
    bus_read(TD, d, oe);
    total++; if (d !== 8'h00) $display("FAIL rst_td got %h exp 00", d); else passed++;
  endtask

  task automatic test_tx_order();
    logic [7:0] d; logic oe, v;
    td_write(8'h11);
    total++; if (pi_tx_valid !== 1'b1 || pi_tx_data !== 8'h11)
      $display("FAIL tx_latency got %b/%h exp 1/11", pi_tx_valid, pi_tx_data); else passed++;
    td_write(8'h22); td_write(8'h33);
    td_write(8'($urandom)); td_write(8'($urandom));
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL tx_stat got %h exp %h", d, exp_stat()); else passed++;
    bus_read(TD, d, oe);
    total++; if (d !== m_td_last) $display("FAIL tx_td_last got %h exp %h", d, m_td_last); else passed++;
    for (int i = 0; i < 6; i++) begin
      pi_pop(v, d);
      total++; if (v !== (tx_q.size() != 0)) $display("FAIL tx_valid[%0d] got %b exp %b", i, v, tx_q.size() != 0); else passed++;
      if (tx_q.size() != 0) begin
        total++; if (d !== tx_q[0]) $display("FAIL tx_data[%0d] got %h exp %h", i, d, tx_q[0]); else passed++;
        void'(tx_q.pop_front());
      end
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d; logic oe, v;
    for (int i = 0; i < DEPTH + 1; i++) td_write(8'($urandom));
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat() || d !== 8'h12) $display("FAIL ovf_stat got %h exp %h", d, exp_stat()); else passed++;
    bus_read(TD, d, oe);
    total++; if (d !== m_td_last) $display("FAIL ovf_td_last got %h exp %h", d, m_td_last); else passed++;
    ctrl_write(8'h04);
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL ovf_clear got %h exp %h", d, exp_stat()); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      pi_pop(v, d);
      total++; if (v !== 1'b1 || d !== tx_q[0]) $display("FAIL ovf_drain[%0d] got %b/%h exp 1/%h", i, v, d, tx_q[0]); else passed++;
      void'(tx_q.pop_front());
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d, e; logic oe, r, er;
    pi_push(8'hA5, r, er);
    total++; if (r !== er) $display("FAIL rx_ready0 got %b exp %b", r, er); else passed++;
    pi_push(8'h5A, r, er);
    bus_read(TC, d, oe);
    total++; if (d !== 8'(rx_q.size())) $display("FAIL rx_tc got %h exp %h", d, rx_q.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      rd_read(d, e);
      total++; if (d !== e) $display("FAIL rx_rd[%0d] got %h exp %h", i, d, e); else passed++;
    end
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL rx_unf_stat got %h exp %h", d, exp_stat()); else passed++;
    ctrl_write(8'h04);
  endtask

  task automatic test_irq();
    logic [7:0] d, e; logic oe, r, er;
    ctrl_write(8'h80);
    repeat (3) @(negedge ti_ph3);
    total++; if (ti_extint_n !== 1'b1) $display("FAIL irq_idle got %b exp 1", ti_extint_n); else passed++;
    pi_push(8'($urandom), r, er);
    total++; if (ti_extint_n !== 1'b1) $display("FAIL irq_delay got %b exp 1", ti_extint_n); else passed++;
    @(negedge ti_ph3);
    total++; if (ti_extint_n !== 1'b0) $display("FAIL irq_assert got %b exp 0", ti_extint_n); else passed++;
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL irq_stat got %h exp %h", d, exp_stat()); else passed++;
    rd_read(d, e);
    total++; if (d !== e) $display("FAIL irq_rd got %h exp %h", d, e); else passed++;
    @(negedge ti_ph3);
    @(negedge ti_ph3);
    total++; if (ti_extint_n !== 1'b1) $display("FAIL irq_release got %b exp 1", ti_extint_n); else passed++;
    ctrl_write(8'h00);
  endtask

  task automatic test_rx_full_simul();
    logic [7:0] d, e, nb; logic oe, r, er;
    for (int i = 0; i < DEPTH; i++) pi_push(8'($urandom), r, er);
    pi_push(8'($urandom), r, er);
    total++; if (r !== er || r !== 1'b0) $display("FAIL full_ready got %b exp %b", r, er); else passed++;
    nb = 8'($urandom);
    @(negedge ti_ph3); ti_a = RD; ti_memen = 0; ti_dbin = 1;
    @(negedge ti_ph3); d = ti_d_out; ti_memen = 1; ti_dbin = 0; pi_rx_data = nb; pi_rx_valid = 1;
    #1 r = pi_rx_ready;
    total++; if (d !== rx_q[0]) $display("FAIL simul_rd got %h exp %h", d, rx_q[0]); else passed++;
    total++; if (r !== 1'b1) $display("FAIL simul_ready got %b exp 1", r); else passed++;
    @(negedge ti_ph3); pi_rx_valid = 0;
    void'(rx_q.pop_front()); rx_q.push_back(nb);
    bus_read(TC, d, oe);
    total++; if (d !== 8'(DEPTH)) $display("FAIL simul_tc got %h exp %h", d, DEPTH); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      rd_read(d, e);
      total++; if (d !== e) $display("FAIL simul_order[%0d] got %h exp %h", i, d, e); else passed++;
    end
    for (int i = 0; i < 3; i++) pi_push(8'($urandom), r, er);
    @(negedge ti_ph3); ti_a = RC; ti_d_in = 8'h02; ti_memen = 0; ti_we = 0;
    pi_rx_data = 8'($urandom); pi_rx_valid = 1;
    @(negedge ti_ph3); ti_memen = 1; ti_we = 1; pi_rx_valid = 0;
    rx_q.delete(); m_rx_ovf = 1;
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL flush_stat got %h exp %h", d, exp_stat()); else passed++;
    bus_read(TC, d, oe);
    total++; if (d !== 8'h00) $display("FAIL flush_tc got %h exp 00", d); else passed++;
    ctrl_write(8'h04);
  endtask

  task automatic test_dev_en();
    logic [7:0] d; logic oe, r, er;
    dev_en = 0;
    bus_write(TD, 8'h5C);
    @(negedge ti_ph3);
    total++; if (pi_tx_valid !== 1'b0) $display("FAIL deven_tx got %b exp 0", pi_tx_valid); else passed++;
    pi_push(8'($urandom), r, er);
    bus_read(RD, d, oe);
    total++; if (oe !== 1'b0 || d !== 8'h00) $display("FAIL deven_rd got %b/%h exp 0/00", oe, d); else passed++;
    dev_en = 1;
    bus_read(TC, d, oe);
    total++; if (d !== 8'(rx_q.size())) $display("FAIL deven_tc got %h exp %h", d, rx_q.size()); else passed++;
    bus_read(TD, d, oe);
    total++; if (d !== m_td_last) $display("FAIL deven_td got %h exp %h", d, m_td_last); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic oe, r, er;
    td_write(8'($urandom)); td_write(8'($urandom));
    pi_push(8'($urandom), r, er);
    @(negedge ti_ph3); ti_a = TD; ti_d_in = 8'h77; ti_memen = 0; ti_we = 0;
    #2 ti_reset_n = 0;
    @(negedge ti_ph3);
    total++; if ({ti_extint_n, pi_tx_valid, pi_rx_ready} !== 3'b101)
      $display("FAIL midrst_ctl got %b exp 101", {ti_extint_n, pi_tx_valid, pi_rx_ready}); else passed++;
    ti_memen = 1; ti_we = 1;
    @(negedge ti_ph3); ti_reset_n = 1;
    model_reset();
    bus_read(RC, d, oe);
    total++; if (d !== exp_stat()) $display("FAIL midrst_stat got %h exp %h", d, exp_stat()); else passed++;
    bus_read(TC, d, oe);
    total++; if (d !== 8'h00) $display("FAIL midrst_tc got %h exp 00", d); else passed++;
    bus_read(TD, d, oe);
    total++; if (d !== 8'h00 || pi_tx_valid !== 1'b0) $display("FAIL midrst_td got %h/%b exp 00/0", d, pi_tx_valid); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] d, e; logic oe, r, er, v;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0, 1: td_write(8'($urandom));
        2: begin
          pi_push(8'($urandom), r, er);
          total++; if (r !== er) $display("FAIL rnd_ready[%0d] got %b exp %b", i, r, er); else passed++;
        end
        3: begin
          rd_read(d, e);
          total++; if (d !== e) $display("FAIL rnd_rd[%0d] got %h exp %h", i, d, e); else passed++;
        end
        4: begin
          pi_pop(v, d);
          total++; if (v !== (tx_q.size() != 0)) $display("FAIL rnd_txv[%0d] got %b exp %b", i, v, tx_q.size() != 0); else passed++;
          if (tx_q.size() != 0) begin
            total++; if (d !== tx_q[0]) $display("FAIL rnd_txd[%0d] got %h exp %h", i, d, tx_q[0]); else passed++;
            void'(tx_q.pop_front());
          end
        end
        5: begin
          bus_read(($urandom_range(0, 1) == 0) ? RC : TC, d, oe);
          e = (ti_a == RC) ? exp_stat() : 8'(rx_q.size());
          total++; if (d !== e) $display("FAIL rnd_reg[%0d] got %h exp %h", i, d, e); else passed++;
        end
        default: if ($urandom_range(0, 3) == 0) ctrl_write(8'($urandom_range(0, 7)));
      endcase
    end
    total++; if (ti_extint_n !== 1'b1) $display("FAIL rnd_irq got %b exp 1", ti_extint_n); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_basic();
    test_irq();
    test_rx_full_simul();
    test_dev_en();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
